// File: rtl/distance_buffer_writer.sv
// ============================================================================
// Module      : distance_buffer_writer
// Description : Producer side of the double-banked per-column distance buffer.
//               The CPU writes the back bank; the GPU reads the front bank
//               through a registered port. Requested bank swaps take effect
//               on the next falling edge of v_sync so a frame never tears.
//               Optional feature macro: DIST_CLEAR_EN. When defined, the new
//               back bank is filled with CLEAR_VALUE after every swap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module distance_buffer_writer #(
    parameter int unsigned             COLUMNS     = 320,
    parameter int unsigned             DIST_WIDTH  = 16,
    parameter logic [DIST_WIDTH-1:0]   CLEAR_VALUE = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_auto,
    input  logic [8:0]            wr_col,
    input  logic [DIST_WIDTH-1:0] wr_distance,
    input  logic                  frame_done,
    input  logic                  v_sync,
    output logic                  swap_ack,
    output logic                  front_bank,
    input  logic [8:0]            rd_col,
    output logic [DIST_WIDTH-1:0] rd_distance,
    output logic                  err_range
);

    localparam int         c_IDX_W = $clog2(2 * COLUMNS);
    localparam logic [8:0] c_LAST  = 9'(COLUMNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1
`ifdef DIST_CLEAR_EN
        , ST_CLEAR = 2'd2
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [8:0]            r_ptr;
    logic                  r_front_bank;
    logic                  r_err_range;
    logic                  r_swap_ack;
    logic                  r_vs_prev;
    logic [DIST_WIDTH-1:0] r_rd_distance;
    logic [DIST_WIDTH-1:0] r_mem [2*COLUMNS];

    logic                  w_wr_ready;
    logic                  w_wr_fire;
    logic [8:0]            w_wr_addr;
    logic                  w_wr_in_range;
    logic                  w_vs_fall;
    logic                  w_swap;
    logic                  w_clearing;
    logic [8:0]            w_ptr_inc;
    logic                  w_mem_we;
    logic [8:0]            w_mem_col;
    logic [DIST_WIDTH-1:0] w_mem_din;
    logic [c_IDX_W-1:0]    w_mem_widx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_rd_in_range;

    assign w_wr_fire     = wr_valid & w_wr_ready;
    assign w_wr_addr     = wr_auto ? r_ptr : wr_col;
    assign w_wr_in_range = 32'(w_wr_addr) < COLUMNS;
    assign w_vs_fall     = r_vs_prev & ~v_sync;
    assign w_swap        = (r_state == ST_PENDING) & w_vs_fall;
    assign w_ptr_inc     = (r_ptr == c_LAST) ? 9'd0 : r_ptr + 9'd1;

`ifdef DIST_CLEAR_EN
    assign w_clearing = (r_state == ST_CLEAR);
`else
    assign w_clearing = 1'b0;
`endif

    // Single write port: the clear sweep (which reuses ptr as its column
    // counter, since the CPU is locked out) or an in-range CPU write.
    assign w_mem_we   = w_clearing | (w_wr_fire & w_wr_in_range);
    assign w_mem_col  = w_clearing ? r_ptr : w_wr_addr;
    assign w_mem_din  = w_clearing ? CLEAR_VALUE : wr_distance;
    assign w_mem_widx = c_IDX_W'((r_front_bank ? 32'd0 : COLUMNS) + 32'(w_mem_col));

    assign w_rd_in_range = 32'(rd_col) < COLUMNS;
    assign w_rd_idx      = c_IDX_W'((r_front_bank ? COLUMNS : 32'd0) + 32'(rd_col));

    assign wr_ready    = w_wr_ready;
    assign swap_ack    = r_swap_ack;
    assign front_bank  = r_front_bank;
    assign rd_distance = r_rd_distance;
    assign err_range   = r_err_range;

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_wr_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_ready = 1'b1;
                if (frame_done) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_vs_fall) begin
`ifdef DIST_CLEAR_EN
                    w_state_next = ST_CLEAR;
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
`ifdef DIST_CLEAR_EN
            ST_CLEAR: begin
                if (r_ptr == c_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bank select, pointer, error flag, swap pulse and v_sync edge history.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr        <= 9'd0;
            r_front_bank <= 1'b0;
            r_err_range  <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_vs_prev    <= 1'b1;
        end else begin
            r_vs_prev  <= v_sync;
            r_swap_ack <= w_swap;
            if (w_swap) begin
                r_front_bank <= ~r_front_bank;
                r_ptr        <= 9'd0;
                r_err_range  <= 1'b0;
            end else begin
                if (w_wr_fire && !w_wr_in_range) begin
                    r_err_range <= 1'b1;
                end
                if ((w_wr_fire && wr_auto) || w_clearing) begin
                    r_ptr <= w_ptr_inc;
                end
            end
        end
    end

    // Back-bank storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_din;
        end
    end

    // Registered front-bank read; out-of-range columns read as zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rd_distance <= '0;
        end else if (w_rd_in_range) begin
            r_rd_distance <= r_mem[w_rd_idx];
        end else begin
            r_rd_distance <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_distance_buffer_writer.sv
// ============================================================================
// Module      : tb_distance_buffer_writer
// Description : Self-checking bench for distance_buffer_writer. A frame-level
//               reference model tracks both banks, the pending swap and the
//               clear sweep; a compare process checks every cycle, and
//               directed scenarios pin hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_distance_buffer_writer;

    localparam int          COLS    = 320;
    localparam logic [15:0] CLEAR_V = 16'hFFFF;

    logic        clk = 1'b0;
    logic        clr;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_auto;
    logic [8:0]  wr_col;
    logic [15:0] wr_distance;
    logic        frame_done;
    logic        v_sync;
    logic        swap_ack;
    logic        front_bank;
    logic [8:0]  rd_col;
    logic [15:0] rd_distance;
    logic        err_range;

    int n_checks = 0;
    int n_pass   = 0;
    int swap_cnt = 0;

    distance_buffer_writer dut (
        .clk         (clk),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_auto     (wr_auto),
        .wr_col      (wr_col),
        .wr_distance (wr_distance),
        .frame_done  (frame_done),
        .v_sync      (v_sync),
        .swap_ack    (swap_ack),
        .front_bank  (front_bank),
        .rd_col      (rd_col),
        .rd_distance (rd_distance),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int  m_mem   [2][COLS];
    bit  m_known [2][COLS];
    int  m_front, m_ptr, m_err, m_swap, m_rd, m_clear_left;
    bit  m_pending, m_vs_prev, m_rd_known;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_front = 0; m_ptr = 0; m_err = 0; m_swap = 0;
            m_rd = 0; m_rd_known = 1; m_clear_left = 0;
            m_pending = 0; m_vs_prev = 1;
        end else begin
            bit ready_now;
            int addr;
            ready_now = !m_pending && (m_clear_left == 0);
            if (rd_col < COLS) begin
                m_rd       = m_mem[m_front][rd_col];
                m_rd_known = m_known[m_front][rd_col];
            end else begin
                m_rd = 0; m_rd_known = 1;
            end
            m_swap = 0;
            if (ready_now && wr_valid) begin
                addr = wr_auto ? m_ptr : int'(wr_col);
                if (addr < COLS) begin
                    m_mem[1-m_front][addr]   = int'(wr_distance);
                    m_known[1-m_front][addr] = 1;
                end else begin
                    m_err = 1;
                end
                if (wr_auto) m_ptr = (m_ptr + 1) % COLS;
            end
            if (m_clear_left > 0) begin
                m_mem[1-m_front][COLS-m_clear_left]   = int'(CLEAR_V);
                m_known[1-m_front][COLS-m_clear_left] = 1;
                m_clear_left--;
            end
            if (m_pending && m_vs_prev && !v_sync) begin
                m_front   = 1 - m_front;
                m_ptr     = 0;
                m_err     = 0;
                m_swap    = 1;
                m_pending = 0;
`ifdef DIST_CLEAR_EN
                m_clear_left = COLS;
`endif
            end else if (ready_now && frame_done) begin
                m_pending = 1;
            end
            m_vs_prev = v_sync;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (swap_ack === 1'b1) swap_cnt++;
        chk("wr_ready",   32'(wr_ready),   32'(!m_pending && m_clear_left == 0));
        chk("swap_ack",   32'(swap_ack),   32'(m_swap));
        chk("front_bank", 32'(front_bank), 32'(m_front));
        chk("err_range",  32'(err_range),  32'(m_err));
        if (m_rd_known) chk("rd_distance", 32'(rd_distance), 32'(m_rd[15:0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("ready_timeout", 32'(wr_ready), 32'd1);
    endtask

    task automatic do_write(input bit auto_m, input int col, input int data);
        wait_ready();
        wr_valid = 1; wr_auto = auto_m; wr_col = 9'(col); wr_distance = 16'(data);
        tick();
        wr_valid = 0; wr_auto = 0;
    endtask

    task automatic do_swap();
        wait_ready();
        frame_done = 1;
        tick();
        frame_done = 0; v_sync = 1;
        tick();
        v_sync = 0;
        tick();
        v_sync = 1;
        tick();
        wait_ready();
    endtask

    task automatic read_col(input int col);
        rd_col = 9'(col);
        tick();
    endtask

    initial begin
        int sc;
        clr = 0; wr_valid = 0; wr_auto = 0; wr_col = 0; wr_distance = 0;
        frame_done = 0; v_sync = 1; rd_col = 9'd5;
        tick(); tick();
        chk("reset_rd",    32'(rd_distance), 32'd0);
        chk("reset_front", 32'(front_bank),  32'd0);
        chk("reset_ready", 32'(wr_ready),    32'd1);
        chk("reset_err",   32'(err_range),   32'd0);
        clr = 1;
        tick();

        // Fill the back bank with its own column index, then swap.
        for (int c = 0; c < COLS; c++) do_write(1, 0, c);
        sc = swap_cnt;
        do_swap();
        chk("swap_once",  32'(swap_cnt - sc), 32'd1);
        chk("front_is_1", 32'(front_bank),    32'd1);
        read_col(319);
        chk("rd_319", 32'(rd_distance), 32'd319);
        read_col(400);
        chk("rd_oob_zero", 32'(rd_distance), 32'd0);

        // Pointer restarted at 0: this auto write lands in column 0.
        do_write(1, 0, 16'hABCD);
        do_write(0, 7, 16'h0012);
        do_write(0, 400, 16'h5555);
        chk("err_set",       32'(err_range),  32'd1);
        chk("front_unmoved", 32'(front_bank), 32'd1);
        do_swap();
        chk("err_cleared", 32'(err_range),  32'd0);
        chk("front_is_0",  32'(front_bank), 32'd0);
        read_col(0);
        chk("ptr_wrapped", 32'(rd_distance), 32'hABCD);
        read_col(7);
        chk("col7_write", 32'(rd_distance), 32'h0012);

        // Two more swaps bring the same bank back to the front.
        do_swap();
        do_swap();
        read_col(7);
`ifdef DIST_CLEAR_EN
        chk("col7_two_frames", 32'(rd_distance), 32'(CLEAR_V));
`else
        chk("col7_two_frames", 32'(rd_distance), 32'h0012);
`endif

        // frame_done while v_sync is already low: no swap until a new fall.
        sc = swap_cnt;
        v_sync = 0;
        tick();
        frame_done = 1;
        tick();
        frame_done = 0;
        repeat (5) tick();
        chk("low_vsync_no_swap", 32'(swap_cnt - sc), 32'd0);
        chk("pending_not_ready", 32'(wr_ready),      32'd0);
        v_sync = 1;
        tick();
        v_sync = 0;
        tick(); tick();
        chk("low_vsync_then_fall", 32'(swap_cnt - sc), 32'd1);
        v_sync = 1;
        wait_ready();

        // Reset while a swap is pending abandons it.
        frame_done = 1;
        tick();
        frame_done = 0;
        tick();
        clr = 0;
        #1;
        chk("rst_front", 32'(front_bank), 32'd0);
        chk("rst_ready", 32'(wr_ready),   32'd1);
        tick();
        clr = 1;
        sc = swap_cnt;
        tick();
        v_sync = 0;
        tick(); tick();
        chk("rst_no_swap", 32'(swap_cnt - sc), 32'd0);
        v_sync = 1;
        tick();

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_valid    = 1'($urandom_range(0, 1));
            wr_auto     = 1'($urandom_range(0, 1));
            wr_col      = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(320, 511))
                                                      : 9'($urandom_range(0, 319));
            wr_distance = 16'($urandom);
            frame_done  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) v_sync = ~v_sync;
            rd_col      = 9'($urandom_range(0, 339));
            tick();
        end
        wr_valid = 0; frame_done = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
